// File: rtl/id_issue_arb.sv
// id_issue_arb: round-robin arbiter of N decoded-instruction sources onto one ID-to-issue register
//
// Optional feature macro: ID_ISSUE_ARB_CF_SERIALIZE_EN
//   defined   -> RUN/BLOCKED machine keeps at most one unresolved branch/jump past this point
//   undefined -> accepts depend only on space and flush_i; resolve_i ignored; blocked_o tied 0
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop held entry, leave BLOCKED, suppress accepts this cycle
//   req_valid_i/data/ctrl  per-port decoded entry, valid and branch/jump flag
//   req_ready_o            per-port accept, one-hot or zero
//   issue_*_o              held entry: data, valid, ctrl-flow flag, source port
//   issue_ack_i            issue stage sampled the held entry
//   resolve_i              outstanding control-flow instruction resolved
//   blocked_o              arbiter is in BLOCKED state
module id_issue_arb #(
    parameter  int NR_PORTS = 2,
    parameter  int DATA_W   = 64,
    localparam int IDX_W    = $clog2(NR_PORTS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [NR_PORTS-1:0]            req_valid_i,
    input  logic [NR_PORTS-1:0][DATA_W-1:0] req_data_i,
    input  logic [NR_PORTS-1:0]            req_ctrl_flow_i,
    output logic [NR_PORTS-1:0]            req_ready_o,
    output logic [DATA_W-1:0]              issue_data_o,
    output logic                           issue_valid_o,
    output logic                           issue_ctrl_flow_o,
    output logic [IDX_W-1:0]               issue_port_o,
    input  logic                           issue_ack_i,
    input  logic                           resolve_i,
    output logic                           blocked_o
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cf_q, cf_d;
    logic [IDX_W-1:0]  port_q, port_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              run;
    logic              accept;
    int                cand;

    // Search rr, rr+1, ... with wrap; the first valid port wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int i = 0; i < NR_PORTS; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NR_PORTS) cand = cand - NR_PORTS;
            if (!gnt_any && req_valid_i[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign accept = gnt_any && run && !flush_i && (!valid_q || issue_ack_i);

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[gnt_idx] = 1'b1;
    end

    // Flush clears only the valid bit; payload, port and flag keep their values.
    always_comb begin
        valid_d = flush_i ? 1'b0 : accept ? 1'b1 : issue_ack_i ? 1'b0 : valid_q;
        data_d  = accept ? req_data_i[gnt_idx] : data_q;
        cf_d    = accept ? req_ctrl_flow_i[gnt_idx] : cf_q;
        port_d  = accept ? gnt_idx : port_q;
        rr_d    = !accept ? rr_q : (gnt_idx == IDX_W'(NR_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cf_q    <= 1'b0;
            port_q  <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cf_q    <= cf_d;
            port_q  <= port_d;
            rr_q    <= rr_d;
        end
    end

`ifdef ID_ISSUE_ARB_CF_SERIALIZE_EN
    typedef enum logic {RUN, BLOCKED} state_e;
    state_e state_q, state_d;

    // Flush wins over resolve; a control-flow accept can only happen in RUN.
    always_comb begin
        state_d = state_q;
        if (flush_i) state_d = RUN;
        else if (state_q == BLOCKED && resolve_i) state_d = RUN;
        else if (accept && req_ctrl_flow_i[gnt_idx]) state_d = BLOCKED;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    assign run       = (state_q == RUN);
    assign blocked_o = (state_q == BLOCKED);
`else
    logic unused_resolve;
    assign unused_resolve = resolve_i;
    assign run            = 1'b1;
    assign blocked_o      = 1'b0;
`endif

    assign issue_valid_o     = valid_q;
    assign issue_data_o      = data_q;
    assign issue_ctrl_flow_o = cf_q;
    assign issue_port_o      = port_q;
endmodule

// File: doc/id_issue_arb.md
# id_issue_arb

Arbitrates N decoded-instruction requesters (e.g. regular fetch/decode path, debug/replay injection port) onto the single ID-to-issue pipeline register feeding the issue stage. Holds one registered issue entry, grants requesters round-robin, and serialises control-flow instructions: at most one unresolved branch/jump is in flight past this point. It sits between the decoders and the issue stage's scoreboard intake and replaces the direct decoder-to-issue-register path when more than one instruction source exists.

## Interface
- NR_PORTS, 2: number of requesters; legal range 2..8.
- DATA_W, 64: width of the opaque decoded-entry payload; the payload is carried unmodified.
- IDX_W, $clog2(NR_PORTS): width of the port index; derived, not overridden.

- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  invalidates the held entry, clears control-flow block.
- req_valid_i  in  NR_PORTS  per-port entry valid.
- req_data_i  in  NR_PORTS×DATA_W  per-port decoded entry.
- req_ctrl_flow_i  in  NR_PORTS  per-port entry is branch/jump.
- req_ready_o  out  NR_PORTS  per-port accept, one-hot or zero.
- issue_data_o  out  DATA_W  held entry.
- issue_valid_o  out  1  held entry valid.
- issue_ctrl_flow_o  out  1  held entry is control flow.
- issue_port_o  out  IDX_W  source port of held entry.
- issue_ack_i  in  1  issue stage sampled the held entry.
- resolve_i  in  1  outstanding control-flow instruction resolved.
- blocked_o  out  1  arbiter in BLOCKED state.

## Operation
- Holding register: valid, data, ctrl_flow, port. Reset: all outputs 0, rr pointer 0, state RUN.
- Space available when !issue_valid_o || issue_ack_i.
- Accept allowed when space available, state RUN, and flush_i low.
- Grant: first port with req_valid_i set, searching from rr pointer upward with wrap (rr, rr+1, …, NR_PORTS-1, 0, …). Exactly that port's req_ready_o is high; all others low. No requesters valid -> req_ready_o = 0.
- On accept from port k: register loads {1, req_data_i[k], req_ctrl_flow_i[k], k}; rr pointer <= (k+1) mod NR_PORTS. Pointer unchanged when nothing is accepted.
- issue_ack_i without accept: valid clears. issue_ack_i with issue_valid_o low: no effect.
- State machine (only with macro, see Configuration):
  - RUN -> BLOCKED when the accepted entry has ctrl_flow = 1.
  - BLOCKED -> RUN on resolve_i or flush_i.
  - In BLOCKED, no accepts; the held entry still drains via issue_ack_i.
  - resolve_i in RUN: ignored.
- flush_i: valid <= 0, state <= RUN, req_ready_o forced 0 that cycle; data/port/ctrl_flow registers keep their values; rr pointer unchanged.
- Simultaneous flush_i and issue_ack_i/resolve_i: flush dominates; result is empty register, RUN.
- Requesters must hold req_valid_i/req_data_i stable until req_ready_o; the arbiter does not require this for correctness. A grant is recomputed every cycle.

## Timing
- Single stage: accept in cycle N -> issue_valid_o high in cycle N+1.
- Back-to-back: with issue_ack_i every cycle and continuous requests, one entry per cycle.
- Combinational paths: req_valid_i, issue_ack_i, flush_i -> req_ready_o. No path from inputs to issue_* outputs.
- resolve_i in cycle N -> first new accept possible in cycle N+1.
- Reset asynchronous; outputs reach reset values without a clock.

## Configuration
- ID_ISSUE_ARB_CF_SERIALIZE_EN defined: RUN/BLOCKED machine present as above; blocked_o reflects state.
- Not defined: no state machine; accepts depend only on space and flush_i; resolve_i ignored; blocked_o tied 0; req_ctrl_flow_i still propagated to issue_ctrl_flow_o.

## Test plan
- Reset, NR_PORTS=2, both req_valid_i = 1, issue_ack_i = 1 every cycle, no ctrl flow -> grants alternate port 0,1,0,1; issue_port_o follows one cycle later.
- Port 1 only valid, register full, issue_ack_i = 0 -> req_ready_o = 00; raise issue_ack_i -> req_ready_o = 10 same cycle, entry appears next cycle.
- Macro on: port 0 accepts ctrl-flow entry -> blocked_o = 1 next cycle; valid requests see req_ready_o = 0 until resolve_i pulse; accept resumes cycle after resolve.
- Held entry valid, BLOCKED, flush_i with issue_ack_i and resolve_i -> next cycle issue_valid_o = 0, blocked_o = 0, req_ready_o was 0 in flush cycle; rr pointer unchanged.
- NR_PORTS=4, rr pointer = 3, ports 1 and 2 valid -> port 1 granted; pointer becomes 2; next grant port 2.
- Macro off: ctrl-flow entries back-to-back on port 0 with ack -> one per cycle, blocked_o stays 0.
